// File: rtl/imem_loader.sv
// imem_loader: boot-time loader for the instruction memory.
// Receives a byte stream [N][4N data bytes, LSB first][XOR checksum],
// writes each assembled word to imem address k (k = 0..N-1), and holds
// the core in reset until the image is complete and the checksum matches.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   rx_valid   source has a byte on rx_data
//   rx_data    stream byte
//   rx_ready   loader accepts a byte (transfer on rx_valid & rx_ready)
//   imem_we    one-cycle write strobe to the instruction memory
//   imem_waddr word address of the write
//   imem_wdata instruction word of the write
//   cpu_reset  active-high core reset; released only after a good load
//   done       image loaded and checksum verified
//   err        bad count or checksum mismatch (sticky until reset)
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_reset,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_COUNT,
    S_DATA,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [8:0] DEPTH9 = 9'(DEPTH);

  state_t        state, state_nx;
  logic          accept;
  logic [AW:0]   n;       // word count, 1..DEPTH
  logic [AW:0]   wcnt;    // words written so far
  logic [1:0]    lane;
  logic [7:0]    xacc;
  logic [23:0]   asm_lo;  // lanes 0..2 of the word being assembled

  assign accept = rx_valid & rx_ready;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_COUNT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_COUNT:
        if (accept) begin
          if (rx_data == 8'd0 || {1'b0, rx_data} > DEPTH9) state_nx = S_ERROR;
          else                                             state_nx = S_DATA;
        end
      S_DATA:
        if (accept && lane == 2'd3 && wcnt == n - (AW+1)'(1)) state_nx = S_CHECK;
      S_CHECK:
        if (accept) state_nx = (rx_data == xacc) ? S_RUN : S_ERROR;
      default: state_nx = state;
    endcase
  end

  // Status outputs are registered decodes of the next state so they are
  // glitch-free and land in the cycle after the deciding byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_ready   <= 1'b0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      n          <= '0;
      wcnt       <= '0;
      lane       <= '0;
      xacc       <= '0;
      asm_lo     <= '0;
    end else begin
      rx_ready  <= (state_nx == S_COUNT) || (state_nx == S_DATA) || (state_nx == S_CHECK);
      cpu_reset <= (state_nx != S_RUN);
      done      <= (state_nx == S_RUN);
      err       <= (state_nx == S_ERROR);
      imem_we   <= 1'b0;
      if (accept) begin
        case (state)
          S_COUNT: begin
            n    <= rx_data[AW:0];
            wcnt <= '0;
            lane <= '0;
            xacc <= '0;
          end
          S_DATA: begin
            xacc <= xacc ^ rx_data;
            lane <= lane + 2'd1;
            case (lane)
              2'd0: asm_lo[7:0]   <= rx_data;
              2'd1: asm_lo[15:8]  <= rx_data;
              2'd2: asm_lo[23:16] <= rx_data;
              default: begin
                imem_we    <= 1'b1;
                imem_waddr <= wcnt[AW-1:0];
                imem_wdata <= {rx_data, asm_lo};
                wcnt       <= wcnt + (AW+1)'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        err;

  imem_loader #(.DEPTH(64), .AW(6)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned stalls   = 0;
  int unsigned wr_count = 0;
  logic [37:0] sb [$];
  logic [31:0] img [0:63];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      logic [37:0] e;
      wr_count++;
      if (sb.size() == 0) begin
        check("unexpected_we", {26'd0, imem_waddr}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("waddr", {26'd0, imem_waddr}, {26'd0, e[37:32]});
        check("wdata", imem_wdata, e[31:0]);
      end
      check("cpu_reset_during_load", {31'd0, cpu_reset}, 32'd1);
    end
  end

  // Present one byte after 'gap' idle cycles; returns at the negedge after it is accepted.
  task automatic send(input logic [7:0] b, input int unsigned gap);
    int unsigned t;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (rx_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
      stalls++;
    end
    if (t >= 40) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("cpu_reset_in_reset", {31'd0, cpu_reset}, 32'd1);
    check("rx_ready_in_reset", {31'd0, rx_ready}, 32'd0);
    sb.delete();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_image(input int unsigned n, input logic [7:0] ck, input int unsigned maxgap);
    send(8'(n), $urandom_range(maxgap, 0));
    for (int unsigned k = 0; k < n; k++) begin
      sb.push_back({6'(k), img[k]});
      for (int unsigned b = 0; b < 4; b++)
        send(img[k][8*b +: 8], $urandom_range(maxgap, 0));
    end
    send(ck, $urandom_range(maxgap, 0));
  endtask

  task automatic check_error_state(input string tag);
    check({tag, "_err"}, {31'd0, err}, 32'd1);
    check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
  endtask

  task automatic check_run_state(input string tag);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    check({tag, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  initial begin
    img[0] = 32'hE04F000F;
    img[1] = 32'hE2802005;
    img[2] = 32'h00000000;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check("rst_waddr", {26'd0, imem_waddr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // N=3 good load, rx_valid held high: one byte per cycle
    stalls = 0;
    wr_count = 0;
    load_image(3, 8'hE7, 0);
    check("n3_run", {31'd0, done}, 32'd1);
    check_run_state("n3");
    check("n3_writes", wr_count, 32'd3);
    check("n3_no_stalls", stalls, 32'd0);
    rx_data = 8'h55;            // still presented: must be ignored in RUN
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    check("n3_run_hold", {31'd0, done}, 32'd1);

    // N=3 with bad checksum
    do_reset();
    load_image(3, 8'hE6, 0);
    check_error_state("badck");
    rx_data = 8'h03;
    repeat (5) @(negedge clk);
    rx_valid = 1'b0;
    check_error_state("badck_trail");

    // Count 0
    do_reset();
    wr_count = 0;
    send(8'h00, 0);
    check_error_state("cnt0");
    rx_data = 8'h01;
    repeat (6) @(negedge clk);
    rx_valid = 1'b0;
    check("cnt0_no_we", wr_count, 32'd0);

    // Count 65 (DEPTH+1)
    do_reset();
    send(8'd65, 0);
    check_error_state("cnt65");
    rx_data = 8'h01;
    repeat (6) @(negedge clk);
    rx_valid = 1'b0;
    check("cnt65_no_we", wr_count, 32'd0);

    // N=64, word k = k: full depth, no wrap, checksum 0x00
    for (int unsigned k = 0; k < 64; k++) img[k] = k;
    do_reset();
    wr_count = 0;
    load_image(64, 8'h00, 0);
    rx_valid = 1'b0;
    check_run_state("n64");
    check("n64_writes", wr_count, 32'd64);

    // N=2 with random gaps of 0..5 idle cycles
    img[0] = 32'hE04F000F;
    img[1] = 32'hE2802005;
    img[2] = 32'h00000000;
    do_reset();
    wr_count = 0;
    load_image(2, 8'hE7, 5);
    rx_valid = 1'b0;
    check_run_state("gaps");
    check("gaps_writes", wr_count, 32'd2);

    // Reset after 6 bytes of an N=3 load, then a full reload
    do_reset();
    send(8'h03, 0);
    sb.push_back({6'd0, img[0]});
    for (int unsigned b = 0; b < 4; b++) send(img[0][8*b +: 8], 0);
    send(img[1][7:0], 0);
    rx_valid = 1'b0;
    check("midrst_word0_written", sb.size(), 32'd0);
    check("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    do_reset();
    check("midrst_ready_after", {31'd0, rx_ready}, 32'd1);
    wr_count = 0;
    load_image(3, 8'hE7, 0);
    rx_valid = 1'b0;
    check_run_state("reload");
    check("reload_writes", wr_count, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
